// File: rtl/alu_16.sv
// 16-bit two-operand ALU (ADD/SUB/AND/OR) with a carry flag and one-cycle registered outputs.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero flag.
module alu_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  op,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    output logic [15:0] o,
    output logic        cout
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    op_t         op_sel;
    logic [15:0] operand_b;
    logic [16:0] adder_sum;
    logic [15:0] next_o;
    logic        next_cout;

    assign op_sel = op_t'(op);

    // ADD and SUB share one adder: op[0] inverts B and supplies the carry-in.
    assign operand_b = op[0] ? ~i1 : i1;
    assign adder_sum = {1'b0, i0} + {1'b0, operand_b} + {16'b0, op[0]};

    always_comb begin
        next_o    = 16'h0000;
        next_cout = 1'b0;
        case (op_sel)
            OP_ADD, OP_SUB: begin
                next_o    = adder_sum[15:0];
                next_cout = adder_sum[16];
            end
            OP_AND: next_o = i0 & i1;
            OP_OR:  next_o = i0 | i1;
            default: begin
                next_o    = 16'h0000;
                next_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o    <= 16'h0000;
            cout <= 1'b0;
        end else begin
            o    <= next_o;
            cout <= next_cout;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero <= 1'b1;
        end else begin
            zero <= (next_o == 16'h0000);
        end
    end
`endif

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: table-driven vectors plus reset and latency sequences.
// Checks the zero flag as well when ALU_ZERO_FLAG_EN is defined.
module tb_alu_16;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_o;
        logic        exp_cout;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [1:0]  op;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] o;
    logic        cout;
`ifdef ALU_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks;
    int errors;

    vec_t vecs [16];

    alu_16 dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .i0    (i0),
        .i1    (i1),
        .o     (o),
        .cout  (cout)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero  (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] v_op, input logic [15:0] a, input logic [15:0] b);
        op = v_op;
        i0 = a;
        i1 = b;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] exp_o, input logic exp_cout);
        checks++;
        if (o !== exp_o || cout !== exp_cout) begin
            errors++;
            $display("[TB] FAIL %s: got o=%h cout=%b, expected o=%h cout=%b",
                     tag, o, cout, exp_o, exp_cout);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (zero !== (exp_o == 16'h0000)) begin
            errors++;
            $display("[TB] FAIL %s zero: got %b, expected %b", tag, zero, (exp_o == 16'h0000));
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{2'b00, 16'haa55, 16'h55aa, 16'hffff, 1'b0};
        vecs[2]  = '{2'b00, 16'hffff, 16'h0001, 16'h0000, 1'b1};
        vecs[3]  = '{2'b00, 16'h0001, 16'h7fff, 16'h8000, 1'b0};
        vecs[4]  = '{2'b01, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{2'b01, 16'haa55, 16'h55aa, 16'h54ab, 1'b1};
        vecs[6]  = '{2'b01, 16'hffff, 16'h0001, 16'hfffe, 1'b1};
        vecs[7]  = '{2'b01, 16'h0001, 16'h7fff, 16'h8002, 1'b0};
        vecs[8]  = '{2'b10, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{2'b10, 16'haa55, 16'h55aa, 16'h0000, 1'b0};
        vecs[10] = '{2'b10, 16'hffff, 16'h0001, 16'h0001, 1'b0};
        vecs[11] = '{2'b10, 16'h0001, 16'h7fff, 16'h0001, 1'b0};
        vecs[12] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{2'b11, 16'haa55, 16'h55aa, 16'hffff, 1'b0};
        vecs[14] = '{2'b11, 16'hffff, 16'h0001, 16'hffff, 1'b0};
        vecs[15] = '{2'b11, 16'h0001, 16'h7fff, 16'h7fff, 1'b0};

        // Reset asserted between clock edges must clear outputs with no edge.
        reset = 1'b0;
        applyStimulus(2'b00, 16'h1234, 16'h1111);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", 16'h0000, 1'b0);

        // Edges while reset is high are ignored.
        @(posedge clk);
        #1 checkOutput("reset_hold", 16'h0000, 1'b0);

        @(negedge clk);
        reset = 1'b0;

        // Back-to-back vectors: inputs change every cycle, result one edge later.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(vecs[k].op, vecs[k].a, vecs[k].b);
            #1;
            if (k == 0) checkOutput("pre_edge_reset_val", 16'h0000, 1'b0);
            else        checkOutput($sformatf("hold_before_vec%0d", k),
                                    vecs[k-1].exp_o, vecs[k-1].exp_cout);
            @(posedge clk);
            #1 checkOutput($sformatf("vec%0d", k), vecs[k].exp_o, vecs[k].exp_cout);
            @(negedge clk);
        end

        // Inputs wiggling between edges must not reach the outputs.
        applyStimulus(2'b00, 16'h0002, 16'h0003);
        #1 applyStimulus(2'b01, 16'h0000, 16'h0001);
        #1 checkOutput("mid_cycle_change", 16'h7fff, 1'b0);
        @(posedge clk);
        #1 checkOutput("last_value_wins", 16'hffff, 1'b0);

        // Mid-stream reset discards the in-flight result.
        @(negedge clk);
        applyStimulus(2'b00, 16'h0010, 16'h0020);
        #2 reset = 1'b1;
        #1 checkOutput("midstream_reset", 16'h0000, 1'b0);
        @(posedge clk);
        #1 checkOutput("midstream_reset_hold", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 checkOutput("first_after_reset", 16'h0030, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
